// File: rtl/riscv_div_unit_if.sv
// rtl/riscv_div_unit_if.sv - request/response handshake bundle for the iterative divider
interface riscv_div_unit_if #(
    parameter int DATA_WIDTH = 32
) ();
    localparam int OP_WIDTH = 7;

    logic [OP_WIDTH-1:0]   op_i;
    logic [DATA_WIDTH-1:0] a_i;
    logic [DATA_WIDTH-1:0] b_i;
    logic                  valid_i;
    logic                  ready_o;
    logic                  flush_i;
    logic [DATA_WIDTH-1:0] result_o;
    logic                  valid_o;
    logic                  ready_i;

    modport master (
        output op_i, a_i, b_i, valid_i, flush_i, ready_i,
        input  ready_o, result_o, valid_o
    );

    modport slave (
        input  op_i, a_i, b_i, valid_i, flush_i, ready_i,
        output ready_o, result_o, valid_o
    );
endinterface

// File: rtl/riscv_div_unit.sv
// rtl/riscv_div_unit.sv - radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module riscv_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    riscv_div_unit_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e                state, state_next;
    logic [DATA_WIDTH-1:0] rem_q, quo_q, div_q, result_q;
    logic [CW-1:0]         cnt_q;
    logic                  is_rem_q, q_neg_q, r_neg_q;

    logic                  is_signed, is_rem, a_neg, b_neg;
    logic                  div_zero, overflow, special, accept, last, step_ok;
    logic [DATA_WIDTH-1:0] a_mag, b_mag, special_result;
    logic [DATA_WIDTH:0]   rem_sh, trial;
    logic [DATA_WIDTH-1:0] rem_step, quo_step, final_result;
    logic                  unused_op;

    // Only the signed and remainder bits of the ALU opcode matter here.
    assign is_signed = bus.op_i[0];
    assign is_rem    = bus.op_i[1];
    assign unused_op = ^bus.op_i[6:2];

    assign a_neg = is_signed & bus.a_i[DATA_WIDTH-1];
    assign b_neg = is_signed & bus.b_i[DATA_WIDTH-1];
    assign a_mag = a_neg ? (~bus.a_i + 1'b1) : bus.a_i;
    assign b_mag = b_neg ? (~bus.b_i + 1'b1) : bus.b_i;

    assign div_zero = (bus.b_i == '0);
    assign overflow = is_signed && (bus.a_i == INT_MIN) && (bus.b_i == '1);
    assign special  = div_zero | overflow;
    assign special_result = div_zero ? (is_rem ? bus.a_i : '1)
                                     : (is_rem ? '0 : INT_MIN);

    assign accept = bus.valid_i && (state == IDLE) && !bus.flush_i;
    assign last   = (cnt_q == CW'(DATA_WIDTH - 1));

    // One restoring step; the extra top bit of trial is the borrow.
    assign rem_sh   = {rem_q, quo_q[DATA_WIDTH-1]};
    assign trial    = rem_sh - {1'b0, div_q};
    assign step_ok  = ~trial[DATA_WIDTH];
    assign rem_step = step_ok ? trial[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
    assign quo_step = {quo_q[DATA_WIDTH-2:0], step_ok};
    assign final_result = is_rem_q ? (r_neg_q ? (~rem_step + 1'b1) : rem_step)
                                   : (q_neg_q ? (~quo_step + 1'b1) : quo_step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = special ? DONE : CALC;
            CALC:    if (last) state_next = DONE;
            DONE:    if (bus.ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.flush_i) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else if (!bus.flush_i) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_rem_q <= is_rem;
                        q_neg_q  <= a_neg ^ b_neg;
                        r_neg_q  <= a_neg;
                        div_q    <= b_mag;
                        rem_q    <= '0;
                        quo_q    <= a_mag;
                        cnt_q    <= '0;
                        if (special) result_q <= special_result;
                    end
                end
                CALC: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) result_q <= final_result;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o  = (state == IDLE);
    assign bus.valid_o  = (state == DONE);
    assign bus.result_o = result_q;
endmodule
